// File: rtl/mips_pkg.sv
// Shared definitions for the single-issue MIPS core front end.
//   - opcode constants decoded by the fetch stage and by CONTROL
//   - fetch FSM state encoding
//   - architectural word size in bytes
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc              current PC
//   instr           instruction being retired
//   branch          CONTROL: instruction is a conditional branch
//   mux_pc_branch   CONTROL: 1 selects the branch-target path
//   mux_branch_jump CONTROL: 0 selects the jump target
//   alu_zero        ALU zero flag for this instruction
//   next_pc         PC to load when the instruction is accepted
module pc_next_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        mux_pc_branch,
    input  logic        mux_branch_jump,
    input  logic        alu_zero,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic        is_bne;
    logic        cond;

    assign pc4    = pc + WORD_BYTES;                    // wraps mod 2^32
    assign is_bne = (instr[31:26] == OP_BNE);
    // BNE takes when the compare was unequal, BEQ when equal.
    assign cond   = is_bne ? ~alu_zero : alu_zero;
    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Jump is checked first so it wins even if CONTROL also raises branch.
    always_comb begin
        if (!mux_branch_jump)
            next_pc = {pc4[31:28], instr[25:0], 2'b00};
        else if (branch && mux_pc_branch && cond)
            next_pc = pc4 + br_off;
        else
            next_pc = pc4;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads one word at a time from
// instruction memory and holds it until decode/execute accepts it.
// Ports:
//   clk, nrst          clock, synchronous active-low reset
//   imem_req/addr      read request and word address (addr == pc)
//   imem_ready/rdata   memory response, valid when ready is high
//   instr_valid/instr  held instruction for decode
//   opcode             instr[31:26] to CONTROL
//   instr_accept       consumer takes the instruction; resolve inputs valid
//   branch, mux_pc_branch, mux_branch_jump, alu_zero  next-PC resolve inputs
//   pc                 current PC
//   retired_count      accepted-instruction counter (wraps)
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             nrst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    input  logic             instr_accept,
    input  logic             branch,
    input  logic             mux_pc_branch,
    input  logic             mux_branch_jump,
    input  logic             alu_zero,
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] retired_count
);

    fetch_state_t state;
    logic [31:0]  next_pc;

    pc_next_calc u_pc_next (
        .pc              (pc),
        .instr           (instr),
        .branch          (branch),
        .mux_pc_branch   (mux_pc_branch),
        .mux_branch_jump (mux_branch_jump),
        .alu_zero        (alu_zero),
        .next_pc         (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            instr         <= '0;
            retired_count <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Memory responses are ignored here; only accept matters.
                    if (instr_accept) begin
                        pc            <= next_pc;
                        retired_count <= retired_count + CNT_W'(1);
                        state         <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded straight from the state register.
    assign imem_req    = (state == S_REQ);
    assign instr_valid = (state == S_HOLD);
    assign imem_addr   = pc;
    assign opcode      = instr[31:26];

    // Word-aligned fetch relies on a word-aligned reset vector.
    always_ff @(posedge clk) begin
        assert (RESET_PC[1:0] == 2'b00);
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by
// randomized fetch/hold/resolve traffic, checked against a transaction-level
// reference model of the PC, held instruction and retired counter.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        nrst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_accept;
    logic        branch;
    logic        mux_pc_branch;
    logic        mux_branch_jump;
    logic        alu_zero;
    logic [31:0] pc;
    logic [31:0] retired_count;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .opcode          (opcode),
        .instr_accept    (instr_accept),
        .branch          (branch),
        .mux_pc_branch   (mux_pc_branch),
        .mux_branch_jump (mux_branch_jump),
        .alu_zero        (alu_zero),
        .pc              (pc),
        .retired_count   (retired_count)
    );

    int errs   = 0;
    int checks = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_instr;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_resolve();
        branch          = 1'($urandom);
        mux_pc_branch   = 1'($urandom);
        mux_branch_jump = 1'($urandom);
        alu_zero        = 1'($urandom);
    endtask

    // Architectural next-PC rule, written as plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] iw,
                                             input logic br, input logic mpb,
                                             input logic mbj, input logic z);
        logic [31:0] seq;
        int          off;
        logic        taken;
        seq = cur + 32'd4;
        if (mbj == 1'b0)
            return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 4);
        taken = (iw[31:26] == 6'd5) ? (z == 1'b0) : (z == 1'b1);
        if (br && mpb && taken) begin
            off = int'($signed(iw[15:0])) * 4;
            return seq + 32'(off);
        end
        return seq;
    endfunction

    // Expect to be in the request state: hold ready low for `waits` cycles,
    // then return `word` and check it is latched.
    task automatic do_fetch(input int waits, input logic [31:0] word);
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            chk("req_wait", 64'(imem_req), 64'd1);
            chk("addr_wait", 64'(imem_addr), 64'(m_pc));
            tick();
        end
        chk("req", 64'(imem_req), 64'd1);
        chk("addr", 64'(imem_addr), 64'(m_pc));
        chk("valid_pre", 64'(instr_valid), 64'd0);
        imem_ready = 1'b1;
        imem_rdata = word;
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        m_instr = word;
        chk("valid", 64'(instr_valid), 64'd1);
        chk("instr", 64'(instr), 64'(m_instr));
        chk("opcode", 64'(opcode), 64'(m_instr[31:26]));
        chk("req_hold", 64'(imem_req), 64'd0);
    endtask

    // Stall `hold` cycles (with stray ready pulses), then accept with the
    // given resolve inputs and check the model's next PC and count.
    task automatic do_accept(input int hold, input logic br, input logic mpb,
                             input logic mbj, input logic z);
        for (int i = 0; i < hold; i++) begin
            instr_accept = 1'b0;
            imem_ready   = 1'($urandom);
            imem_rdata   = $urandom;
            rand_resolve();
            tick();
            chk("hold_instr", 64'(instr), 64'(m_instr));
            chk("hold_valid", 64'(instr_valid), 64'd1);
            chk("hold_noreq", 64'(imem_req), 64'd0);
        end
        imem_ready      = 1'b0;
        instr_accept    = 1'b1;
        branch          = br;
        mux_pc_branch   = mpb;
        mux_branch_jump = mbj;
        alu_zero        = z;
        tick();
        instr_accept = 1'b0;
        rand_resolve();
        m_pc  = ref_next(m_pc, m_instr, br, mpb, mbj, z);
        m_cnt = m_cnt + 32'd1;
        chk("pc", 64'(pc), 64'(m_pc));
        chk("retired", 64'(retired_count), 64'(m_cnt));
        chk("req_after", 64'(imem_req), 64'd1);
    endtask

    task automatic seq_step(input logic [31:0] word);
        do_fetch(0, word);
        do_accept(0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] w;
        int          kind;
        nrst = 1'b0; imem_ready = 1'b0; imem_rdata = '0; instr_accept = 1'b0;
        branch = 1'b0; mux_pc_branch = 1'b0; mux_branch_jump = 1'b1; alu_zero = 1'b0;
        m_pc = 32'h0; m_cnt = 32'h0; m_instr = 32'h0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_opcode", 64'(opcode), 64'd0);
        chk("rst_cnt", 64'(retired_count), 64'd0);
        nrst = 1'b1;
        tick();                             // idle cycle after release
        chk("idle_then_req", 64'(imem_req), 64'd1);

        // sequential fetch 0, 4, 8
        seq_step(32'h0000_0020);
        seq_step(32'h0000_0020);
        seq_step(32'h0000_0020);
        chk("cnt3", 64'(retired_count), 64'd3);
        seq_step(32'h0000_0020);            // pc -> 0x10

        // wait states at 0x10, stray ready pulses while holding
        do_fetch(3, 32'h0123_4567);
        do_accept(3, 1'b0, 1'b0, 1'b1, 1'b0);
        seq_step(32'h0000_0020);
        seq_step(32'h0000_0020);
        seq_step(32'h0000_0020);            // pc = 0x20
        chk("at_0x20", 64'(pc), 64'h20);

        do_fetch(0, 32'h1000_0003);         // BEQ taken
        do_accept(0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("beq_taken", 64'(pc), 64'h30);
        do_fetch(0, 32'h1000_FFFB);         // back to 0x20
        do_accept(0, 1'b1, 1'b1, 1'b1, 1'b1);
        do_fetch(0, 32'h1000_0003);         // BEQ not taken
        do_accept(0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("beq_not", 64'(pc), 64'h24);
        do_fetch(0, 32'h1400_FFFE);         // BNE taken back to 0x20
        do_accept(0, 1'b1, 1'b1, 1'b1, 1'b0);
        do_fetch(0, 32'h1400_FFFE);
        do_accept(0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("bne_taken", 64'(pc), 64'h1C);

        do_fetch(0, 32'h0800_0040);         // jump to 0x100
        do_accept(0, 1'b1, 1'b1, 1'b0, 1'b1);
        do_fetch(0, 32'h0800_0040);         // jump wins over branch, 5-cycle stall
        do_accept(5, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("jump_wins", 64'(pc), 64'h100);

        do_fetch(0, 32'h0800_0000);         // jump to 0
        do_accept(0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_fetch(0, 32'h1000_FFFE);         // branch back to 0xFFFF_FFFC
        do_accept(0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("at_top", 64'(pc), 64'hFFFF_FFFC);
        seq_step(32'h0000_0020);
        chk("pc_wrap", 64'(pc), 64'h0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            w    = $urandom;
            case (kind)
                0: w = {6'b000100, w[25:16], 16'($signed(5'($urandom)))};
                1: w = {6'b000101, w[25:16], 16'($signed(5'($urandom)))};
                2: w = {6'b000010, 26'($urandom_range(0, 255))};
                default: ;
            endcase
            do_fetch(int'($urandom_range(0, 2)), w);
            do_accept(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        // reset while a request is being answered
        chk("pre_rst_req", 64'(imem_req), 64'd1);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        nrst       = 1'b0;
        tick();
        imem_ready = 1'b0;
        m_pc = 32'h0; m_cnt = 32'h0; m_instr = 32'h0;
        chk("mid_rst_req", 64'(imem_req), 64'd0);
        chk("mid_rst_valid", 64'(instr_valid), 64'd0);
        chk("mid_rst_instr", 64'(instr), 64'd0);
        chk("mid_rst_pc", 64'(pc), 64'd0);
        chk("mid_rst_cnt", 64'(retired_count), 64'd0);
        nrst = 1'b1;
        tick();
        seq_step(32'h0000_0020);
        chk("post_rst_pc", 64'(pc), 64'h4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage. Owns the PC, issues word reads to instruction memory over a req/ready handshake, and holds the fetched word for the decode stage.
- Presents opcode (instr[31:26]) to the main control decoder and consumes that decoder's branch/jump outputs, plus the ALU zero flag, to choose the next PC.
- Sits between instruction memory and CONTROL/register-file decode in the single-issue MIPS core.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- nrst  in  1  reset, synchronous, active-low
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word-aligned fetch address; equals pc
- imem_ready  in  1  memory has imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr/opcode hold a valid instruction
- instr  out  32  held instruction word
- opcode  out  6  instr[31:26], to CONTROL
- instr_accept  in  1  decode/execute consumes the instruction this cycle; resolve inputs are valid in the same cycle
- branch  in  1  from CONTROL
- mux_pc_branch  in  1  from CONTROL; 1 = branch-target path selected
- mux_branch_jump  in  1  from CONTROL; 0 = jump
- alu_zero  in  1  ALU zero flag for the held instruction
- pc  out  32  current PC
- retired_count  out  CNT_W  number of accepted instructions

Behaviour:
- All state updates on the rising clk edge. nrst is sampled at that edge and overrides every other input, including mid-handshake.
- Reset values:
  - state = S_IDLE, pc = RESET_PC, instr = 0, retired_count = 0.
  - imem_req = 0, instr_valid = 0, opcode = 0.
  - opcode 0 decodes as R-type, so downstream gates on instr_valid.
- Outputs are Moore outputs:
  - imem_req = (state == S_REQ).
  - instr_valid = (state == S_HOLD).
  - imem_addr = pc.
- State S_IDLE: imem_req = 0; unconditionally goes to S_REQ on the next cycle. Gives one idle cycle after reset release.
- State S_REQ:
  - imem_req = 1; imem_addr stays stable until ready.
  - If imem_ready = 1: instr <= imem_rdata, go to S_HOLD.
  - Otherwise stay in S_REQ; no timeout.
- State S_HOLD:
  - instr_valid = 1; instr is stable.
  - imem_ready is ignored in this state.
  - On instr_accept = 1: pc <= next_pc, retired_count += 1 (wraps modulo 2^CNT_W), go to S_REQ.
  - Otherwise stay in S_HOLD.
- next_pc computation, with pc4 = pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0):
  - is_bne = (instr[31:26] == 6'b000101).
  - cond = is_bne ? ~alu_zero : alu_zero.
  - If mux_branch_jump == 0 (jump): next_pc = {pc4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - Else if branch & mux_pc_branch & cond: next_pc = pc4 + {sext(instr[15:0]), 2'b00}.
  - Else: next_pc = pc4.
- Resolve inputs are sampled only in the accept cycle; their values in other cycles are don't-care.
- Throughput: minimum 2 cycles per instruction, for ready in the first S_REQ cycle and accept in the first S_HOLD cycle.
- Latency: ready at cycle t → instr_valid at t+1.
- imem_addr[1:0] is always 00 by construction. An assertion checks RESET_PC[1:0] == 0.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: R-type 000000, J 000010, BEQ 000100, BNE 000101.
  - state encoding: S_IDLE, S_REQ, S_HOLD.
  - word size 4.
- One sub-module, pc_next_calc: combinational next_pc from pc, instr, branch, mux_pc_branch, mux_branch_jump, alu_zero.

Test Plan:
- Reset then sequential fetch: nrst low 2 cycles, RESET_PC = 0, ready immediate, accept immediate with mux_branch_jump = 1 and branch = 0 → imem_addr sequence 0, 4, 8; first instr_valid 2 cycles after nrst release; retired_count = 3 after the third accept.
- Wait states: ready held low 3 cycles at pc = 0x10 → imem_req high and imem_addr = 0x10 for 4 cycles; rdata captured only on the ready cycle; ready pulses while in S_HOLD are ignored.
- BEQ/BNE:
  - pc = 0x20, instr = 0x1000_0003 (BEQ, imm = 3), branch = 1, mux_pc_branch = 1, alu_zero = 1 → next pc = 0x30.
  - Same case with alu_zero = 0 → next pc = 0x24.
  - BNE 0x1400_FFFE with alu_zero = 0 → next pc = 0x1C.
- Jump: pc = 0x4000_0100, instr = 0x0800_0040, mux_branch_jump = 0, branch = 1 → next pc = 0x4000_0100 (jump wins over branch).
- Backpressure and wrap: instr_accept low 5 cycles → instr stable, no new req. pc = 0xFFFF_FFFC sequential → next pc = 0x0000_0000.
- Reset mid-handshake: nrst low while in S_REQ with ready = 1 → instr not captured, pc = RESET_PC, imem_req = 0 the next cycle, retired_count = 0.
